// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and constants for the bit-serial arithmetic blocks
//
// Purpose : FSM state encoding and default operand width used by the serial
//           subtractor and its companions.
// Contents: state_t {IDLE, SHIFT, DONE}, DEFAULT_WIDTH.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor cell
//
// Purpose : computes a - b - bin for a single bit position.
// Ports   : a, b, bin (in)  - minuend bit, subtrahend bit, borrow-in
//           d (out)          - difference bit
//           bout (out)       - borrow-out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when a and b are equal and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_4_bit.sv
// rtl/serial_subtractor_4_bit.sv - bit-serial subtractor D = A - B - Bin, LSB first
//
// Purpose : processes one bit per clock through a single full_subtractor cell,
//           carrying the borrow in a flop, framed by a start/busy/done handshake.
// Ports   : clk          (in)  rising-edge clock
//           rst_n        (in)  synchronous active-low reset
//           start        (in)  request, sampled only in IDLE
//           A, B [W]     (in)  minuend / subtrahend, captured on accepted start
//           Bin          (in)  borrow-in, captured on accepted start
//           busy         (out) high while bits are being processed
//           done         (out) single-cycle completion pulse
//           D [W]        (out) registered difference, held until next completion
//           Bout         (out) registered borrow-out
import serial_arith_pkg::*;

module serial_subtractor_4_bit #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  // Counter only needs to index bits 0..WIDTH-1; it is cleared on completion
  // rather than wrapping, so no extra headroom bit is required.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_work;
  logic             r_borrow;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic             w_diff;
  logic             w_bout;
  logic [WIDTH-1:0] w_work_next;

  full_subtractor u_fs (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_borrow),
    .d    (w_diff),
    .bout (w_bout)
  );

  // Difference bits enter at the MSB and move down, so after WIDTH shifts
  // bit 0 of the result sits at the LSB.
  assign w_work_next = {w_diff, r_work[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_work   <= '0;
      r_borrow <= 1'b0;
      r_d      <= '0;
      r_bout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh   <= A;
            r_b_sh   <= B;
            // Borrow-in seeds the borrow flop so bit 0 needs no special case.
            r_borrow <= Bin;
            r_work   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end

        SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_work   <= w_work_next;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            r_d     <= w_work_next;
            r_bout  <= w_bout;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign D    = r_d;
  assign Bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_4_bit.sv
// tb/tb_serial_subtractor_4_bit.sv - self-checking bench for serial_subtractor_4_bit
module tb_serial_subtractor_4_bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;

  serial_subtractor_4_bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_pulses = 0;
  bit chk_en = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Behavioural model: an operation is accepted when idle and start is seen,
  // completes W edges later with plain unsigned arithmetic, then one DONE cycle.
  int           m_rem   = 0;
  bit           m_busy  = 1'b0;
  bit           m_done  = 1'b0;
  logic [W-1:0] m_d     = '0;
  logic         m_bout  = 1'b0;
  logic [W-1:0] cap_a   = '0;
  logic [W-1:0] cap_b   = '0;
  logic         cap_bin = 1'b0;

  always @(posedge clk) begin
    logic [W:0] diff;
    if (!rst_n) begin
      m_rem = 0; m_busy = 1'b0; m_done = 1'b0; m_d = '0; m_bout = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        diff   = {1'b0, cap_a} - {1'b0, cap_b} - (W+1)'(cap_bin);
        m_d    = diff[W-1:0];
        m_bout = diff[W];
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (start) begin
      cap_a = A; cap_b = B; cap_bin = Bin;
      m_busy = 1'b1;
      m_rem  = W;
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] sum;
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("D",    32'(D),    32'(m_d));
      check("Bout", 32'(Bout), 32'(m_bout));
      check("busy_and_done", 32'(busy & done), 32'd0);
      if (done) begin
        done_pulses++;
        sum = D + cap_b + W'(cap_bin);
        check("adder_D_plus_B_plus_Bin", 32'(sum), 32'(cap_a));
      end
    end
  end

  // Waits for done (bounded), counting busy cycles on the way.
  task automatic wait_done(output bit seen, output int busy_cnt);
    seen = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic [W-1:0] exp_d, input logic exp_bout);
    bit seen;
    int bc;
    @(negedge clk);
    A = a; B = b; Bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(seen, bc);
    check("op_done_seen", 32'(seen), 32'd1);
    check("op_busy_cycles", 32'(bc), 32'd4);
    check("op_D_literal", 32'(D), 32'(exp_d));
    check("op_Bout_literal", 32'(Bout), 32'(exp_bout));
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    int bc;
    int pulses0;
    logic [8:0] v;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_D",    32'(D),    32'd0);
    check("reset_Bout", 32'(Bout), 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    run_op(4'ha, 4'h5, 1'b0, 4'h5, 1'b0);
    run_op(4'h5, 4'ha, 1'b0, 4'hb, 1'b1);
    run_op(4'ha, 4'h5, 1'b1, 4'h4, 1'b0);
    run_op(4'h0, 4'h0, 1'b1, 4'hf, 1'b1);
    run_op(4'h0, 4'h0, 1'b0, 4'h0, 1'b0);

    // Restart and operand change mid-run are ignored.
    pulses0 = done_pulses;
    @(negedge clk);
    A = 4'h3; B = 4'h1; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'hf; B = 4'h0; Bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(seen, bc);
    check("midrun_done_seen", 32'(seen), 32'd1);
    check("midrun_D", 32'(D), 32'h2);
    check("midrun_Bout", 32'(Bout), 32'd0);
    repeat (4) @(negedge clk);
    check("midrun_one_pulse", 32'(done_pulses - pulses0), 32'd1);

    // Reset during SHIFT aborts with no done pulse.
    pulses0 = done_pulses;
    A = 4'h9; B = 4'h2; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_D", 32'(D), 32'd0);
    check("abort_Bout", 32'(Bout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    check("abort_no_pulse", 32'(done_pulses - pulses0), 32'd0);
    run_op(4'h7, 4'h3, 1'b1, 4'h3, 1'b0);

    // Reset wins over start at the same edge.
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    check("reset_beats_start", 32'(busy), 32'd0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);

    // Exhaustive back-to-back sweep with start held high; operands scrambled
    // after capture to show they are not re-sampled.
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      A = v[8:5]; B = v[4:1]; Bin = v[0]; start = 1'b1;
      repeat (5) begin
        @(negedge clk);
        A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);

    // Random traffic including occasional resets.
    for (int i = 0; i < 2000; i++) begin
      start = ($urandom_range(0, 3) != 0);
      A     = W'($urandom);
      B     = W'($urandom);
      Bin   = 1'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_4_bit.md
# serial_subtractor_4_bit

Bit-serial subtractor computing D = A − B − Bin over WIDTH clock cycles with one full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the combinational ripple-carry 4-bit adder. Results are checked by feeding D and B back through that adder: A = D + B + Bin. A start/busy/done handshake frames each operation, and the result register holds the last answer until the next completion.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE
- A  in  WIDTH  minuend; captured on accepted start
- B  in  WIDTH  subtrahend; captured on accepted start
- Bin  in  1  borrow-in; captured on accepted start
- busy  out  1  high while bits are being processed
- done  out  1  single-cycle completion pulse
- D  out  WIDTH  difference (A − B − Bin) mod 2^WIDTH, registered
- Bout  out  1  borrow-out: 1 iff A < B + Bin (unsigned), registered

## Operation
- FSM states:
  - IDLE: busy=0, done=0. start=1 at an edge → capture A, B and Bin into shift registers; clear bit counter; go to SHIFT.
  - SHIFT: busy=1. Each edge processes bit cnt (LSB first) through the full subtractor, using the borrow flop as borrow-in:
    - difference bit shifts into the working register;
    - new borrow is written to the borrow flop;
    - cnt increments.
    - On the edge processing bit WIDTH−1, D and Bout load from the working register and final borrow; go to DONE.
  - DONE: done=1, busy=0. Next edge → IDLE unconditionally.
- start in SHIFT or DONE is ignored and not queued.
- A, B and Bin changes after capture have no effect on the running operation.
- D and Bout change only on the completion edge; they hold the previous result throughout SHIFT.
- Arithmetic is unsigned; wrap-around is modulo 2^WIDTH.
  - Example: 0 − 0 − 1 gives D=all ones, Bout=1.
- Counter width is $clog2(WIDTH); the counter must not overflow for any legal WIDTH.

## Timing
- Reset (rst_n=0 at an edge), applied in any state:
  - state=IDLE; busy=0, done=0, D=0, Bout=0;
  - borrow flop, working and shift registers cleared.
  - An operation in progress is aborted; no done pulse is produced for it.
- start accepted at edge E0:
  - busy=1 after E0;
  - bits 0..WIDTH−1 are processed at edges E1..EWIDTH;
  - D, Bout and done are valid after EWIDTH;
  - done=0 and busy=0 after EWIDTH+1.
- Latency from accepted start to done: WIDTH cycles. Throughput: one operation per WIDTH+2 cycles.
  - The earliest next accepted start is at EWIDTH+2, with start held high from DONE.
- start and rst_n low at the same edge: reset wins.
- busy and done are never high together.

## Structure
- Shared package serial_arith_pkg contains:
  - state typedef {IDLE, SHIFT, DONE};
  - default width constant (4).
- Sub-module full_subtractor (combinational):
  - inputs a, b, bin; outputs d = a^b^bin, bout = (~a&b) | (~(a^b)&bin).
- The top level contains the FSM, counter, shift/working registers, borrow flop and output registers.

## Test plan
- A=4'ha, B=4'h5, Bin=0, start pulse → busy for 4 cycles; then done one cycle with D=4'h5, Bout=0.
- A=4'h5, B=4'ha, Bin=0 → D=4'hb, Bout=1. A=4'ha, B=4'h5, Bin=1 → D=4'h4, Bout=0.
- A=0, B=0, Bin=1 → D=4'hf, Bout=1. A=0, B=0, Bin=0 → D=0, Bout=0.
- start re-asserted at cycle 2 of SHIFT, and A changed mid-run → ignored; result matches the captured operands; exactly one done pulse.
- rst_n low during SHIFT → D=0, Bout=0, busy=0 next cycle; no done pulse; the next start completes normally.
- Exhaustive sweep of all A, B and Bin values with start held high (back-to-back operations):
  - each completion satisfies {Bout,D} = A − B − Bin mod 2^5;
  - the combinational adder check D + B + Bin = A (mod 16) passes.
